mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch / data access) in front of a
// single shared memory port with a fixed number of wait states per access.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_done,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              needWait
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT_CYCLES);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_DATA  = 1'b1;

    logic [0:0]        state, state_nxt;
    logic              owner, owner_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ADDR_W-1:0] lat_addr_nxt;
    logic [DATA_W-1:0] lat_wdata_nxt;
    logic              lat_we, lat_we_nxt;
    logic              fetch_done_nxt, data_done_nxt;
    logic [DATA_W-1:0] fetch_rdata_nxt, data_rdata_nxt;
    logic              mem_we_nxt, mem_re_nxt;

    // Stall while any request is outstanding and not completing this cycle.
    assign needWait = (fetch_req & ~fetch_done) | (data_req & ~data_done);

    // State register; latched address/data drive the memory port directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_FETCH;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            lat_we      <= 1'b0;
            fetch_done  <= 1'b0;
            data_done   <= 1'b0;
            fetch_rdata <= '0;
            data_rdata  <= '0;
            mem_we      <= 1'b0;
            mem_re      <= 1'b0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            cnt         <= cnt_nxt;
            mem_addr    <= lat_addr_nxt;
            mem_wdata   <= lat_wdata_nxt;
            lat_we      <= lat_we_nxt;
            fetch_done  <= fetch_done_nxt;
            data_done   <= data_done_nxt;
            fetch_rdata <= fetch_rdata_nxt;
            data_rdata  <= data_rdata_nxt;
            mem_we      <= mem_we_nxt;
            mem_re      <= mem_re_nxt;
        end
    end

    // Grant, wait-state counting and completion; a requester whose done is
    // high is still holding its level request and must not be re-granted.
    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        cnt_nxt         = cnt;
        lat_addr_nxt    = mem_addr;
        lat_wdata_nxt   = mem_wdata;
        lat_we_nxt      = lat_we;
        fetch_done_nxt  = 1'b0;
        data_done_nxt   = 1'b0;
        fetch_rdata_nxt = fetch_rdata;
        data_rdata_nxt  = data_rdata;
        mem_we_nxt      = 1'b0;
        mem_re_nxt      = 1'b0;

        case (state)
            IDLE: begin
                if (data_req && !data_done) begin
                    state_nxt     = ACCESS;
                    owner_nxt     = OWN_DATA;
                    cnt_nxt       = '0;
                    lat_addr_nxt  = data_addr;
                    lat_wdata_nxt = data_wdata;
                    lat_we_nxt    = data_we;
                    mem_we_nxt    = data_we;
                    mem_re_nxt    = ~data_we;
                end else if (fetch_req && !fetch_done) begin
                    state_nxt    = ACCESS;
                    owner_nxt    = OWN_FETCH;
                    cnt_nxt      = '0;
                    lat_addr_nxt = fetch_addr;
                    lat_we_nxt   = 1'b0;
                    mem_re_nxt   = 1'b1;
                end
            end
            ACCESS: begin
                if (cnt == WAIT_CNT) begin
                    state_nxt = IDLE;
                    if (owner == OWN_DATA) begin
                        data_done_nxt = 1'b1;
                        if (!lat_we) data_rdata_nxt = mem_rdata;
                    end else begin
                        fetch_done_nxt  = 1'b1;
                        fetch_rdata_nxt = mem_rdata;
                    end
                end else begin
                    cnt_nxt    = cnt + CNT_W'(1);
                    mem_we_nxt = lat_we;
                    mem_re_nxt = ~lat_we;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (WAIT_CYCLES=2 and =0 builds).
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        fetch_req, data_req, data_we;
    logic [15:0] fetch_addr, data_addr, data_wdata, mem_rdata;
    logic [15:0] fetch_rdata, data_rdata, mem_addr, mem_wdata;
    logic        fetch_done, data_done, mem_we, mem_re, need_wait;

    logic        f0_req;
    logic [15:0] f0_addr, m0_rdata;
    logic [15:0] f0_rdata, d0_rdata, m0_addr, m0_wdata;
    logic        f0_done, d0_done, m0_we, m0_re, n0_wait;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_rdata(fetch_rdata), .fetch_done(fetch_done),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .needWait(need_wait)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .fetch_req(f0_req), .fetch_addr(f0_addr),
        .fetch_rdata(f0_rdata), .fetch_done(f0_done),
        .data_req(1'b0), .data_we(1'b0), .data_addr(16'h0000),
        .data_wdata(16'h0000), .data_rdata(d0_rdata), .data_done(d0_done),
        .mem_addr(m0_addr), .mem_wdata(m0_wdata), .mem_we(m0_we),
        .mem_re(m0_re), .mem_rdata(m0_rdata), .needWait(n0_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        fetch_addr = 16'h0; data_addr = 16'h0; data_wdata = 16'h0; mem_rdata = 16'h0;
        f0_req = 1'b0; f0_addr = 16'h0; m0_rdata = 16'h0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL reset_fetch_done got=%b exp=0", fetch_done); end
        checks++; if (data_done !== 1'b0) begin failures++; $display("FAIL reset_data_done got=%b exp=0", data_done); end
        checks++; if (fetch_rdata !== 16'h0) begin failures++; $display("FAIL reset_fetch_rdata got=%h exp=0000", fetch_rdata); end
        checks++; if (data_rdata !== 16'h0) begin failures++; $display("FAIL reset_data_rdata got=%h exp=0000", data_rdata); end
        checks++; if ({mem_we, mem_re} !== 2'b00) begin failures++; $display("FAIL reset_mem_strobes got=%b exp=00", {mem_we, mem_re}); end
        checks++; if ({mem_addr, mem_wdata} !== 32'h0) begin failures++; $display("FAIL reset_mem_bus got=%h exp=00000000", {mem_addr, mem_wdata}); end
        checks++; if (need_wait !== 1'b0) begin failures++; $display("FAIL reset_need_wait got=%b exp=0", need_wait); end
        checks++; if ({f0_done, m0_re} !== 2'b00) begin failures++; $display("FAIL reset_w0_idle got=%b exp=00", {f0_done, m0_re}); end
    endtask

    // Fetch read; mem_rdata only correct on the last access cycle.
    task automatic test_fetch_read();
        fetch_req = 1'b1; fetch_addr = 16'h0010; mem_rdata = 16'hDEAD;
        #1;
        checks++; if (need_wait !== 1'b1) begin failures++; $display("FAIL fetch_need_wait c0 got=%b exp=1", need_wait); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) fetch_addr = 16'h0777;
            checks++; if ({mem_re, mem_we} !== 2'b10) begin failures++; $display("FAIL fetch_strobes c%0d got=%b exp=10", c, {mem_re, mem_we}); end
            checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL fetch_mem_addr c%0d got=%h exp=0010", c, mem_addr); end
            checks++; if ({fetch_done, need_wait} !== 2'b01) begin failures++; $display("FAIL fetch_wait c%0d got=%b exp=01", c, {fetch_done, need_wait}); end
            if (c == 3) mem_rdata = 16'hBEEF;
        end
        tick();
        checks++; if (fetch_done !== 1'b1) begin failures++; $display("FAIL fetch_done c4 got=%b exp=1", fetch_done); end
        checks++; if (fetch_rdata !== 16'hBEEF) begin failures++; $display("FAIL fetch_rdata c4 got=%h exp=beef", fetch_rdata); end
        checks++; if ({mem_re, need_wait} !== 2'b00) begin failures++; $display("FAIL fetch_end c4 got=%b exp=00", {mem_re, need_wait}); end
        fetch_req = 1'b0; mem_rdata = 16'h0BAD;
        tick();
        checks++; if ({fetch_done, mem_re} !== 2'b00) begin failures++; $display("FAIL fetch_pulse c5 got=%b exp=00", {fetch_done, mem_re}); end
        checks++; if (fetch_rdata !== 16'hBEEF) begin failures++; $display("FAIL fetch_rdata_hold c5 got=%h exp=beef", fetch_rdata); end
    endtask

    // Simultaneous requests: data first, fetch granted in data_done cycle.
    task automatic test_priority_back_to_back();
        fetch_req = 1'b1; fetch_addr = 16'h0040;
        data_req = 1'b1; data_we = 1'b0; data_addr = 16'h0300; mem_rdata = 16'h1111;
        tick();
        checks++; if (mem_addr !== 16'h0300) begin failures++; $display("FAIL prio_first_addr c1 got=%h exp=0300", mem_addr); end
        tick(); tick(); tick();
        checks++; if ({data_done, fetch_done} !== 2'b10) begin failures++; $display("FAIL prio_data_done c4 got=%b exp=10", {data_done, fetch_done}); end
        checks++; if (data_rdata !== 16'h1111) begin failures++; $display("FAIL prio_data_rdata c4 got=%h exp=1111", data_rdata); end
        checks++; if (need_wait !== 1'b1) begin failures++; $display("FAIL prio_need_wait c4 got=%b exp=1", need_wait); end
        data_req = 1'b0; mem_rdata = 16'h2222;
        tick();
        checks++; if ({mem_re, mem_addr} !== {1'b1, 16'h0040}) begin failures++; $display("FAIL b2b_fetch_grant c5 got=%b/%h exp=1/0040", mem_re, mem_addr); end
        tick(); tick();
        checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL b2b_early_done c7 got=%b exp=0", fetch_done); end
        tick();
        checks++; if ({fetch_done, fetch_rdata} !== {1'b1, 16'h2222}) begin failures++; $display("FAIL b2b_fetch_done c8 got=%b/%h exp=1/2222", fetch_done, fetch_rdata); end
        checks++; if (data_rdata !== 16'h1111) begin failures++; $display("FAIL b2b_data_hold c8 got=%h exp=1111", data_rdata); end
        fetch_req = 1'b0;
        tick();
    endtask

    // Data write: strobe and bus held, read data untouched.
    task automatic test_write();
        data_req = 1'b1; data_we = 1'b1; data_addr = 16'h0200; data_wdata = 16'h1234;
        mem_rdata = 16'h5555;
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) begin data_wdata = 16'hFFFF; data_addr = 16'hFFFF; end
            checks++; if ({mem_we, mem_re} !== 2'b10) begin failures++; $display("FAIL wr_strobes c%0d got=%b exp=10", c, {mem_we, mem_re}); end
            checks++; if ({mem_addr, mem_wdata} !== 32'h0200_1234) begin failures++; $display("FAIL wr_bus c%0d got=%h exp=02001234", c, {mem_addr, mem_wdata}); end
        end
        tick();
        checks++; if (data_done !== 1'b1) begin failures++; $display("FAIL wr_done c4 got=%b exp=1", data_done); end
        checks++; if (data_rdata !== 16'h1111) begin failures++; $display("FAIL wr_rdata c4 got=%h exp=1111", data_rdata); end
        data_req = 1'b0; data_we = 1'b0;
        tick();
        checks++; if ({mem_we, data_done, mem_wdata} !== {2'b00, 16'h1234}) begin failures++; $display("FAIL wr_after c5 got=%b/%h exp=00/1234", {mem_we, data_done}, mem_wdata); end
    endtask

    // A still-held request is not re-granted in its own done cycle.
    task automatic test_mask();
        fetch_req = 1'b1; fetch_addr = 16'h0080; mem_rdata = 16'h7777;
        tick(); tick(); tick(); tick();
        checks++; if ({fetch_done, fetch_rdata} !== {1'b1, 16'h7777}) begin failures++; $display("FAIL mask_done c4 got=%b/%h exp=1/7777", fetch_done, fetch_rdata); end
        tick();
        checks++; if ({mem_re, fetch_done} !== 2'b00) begin failures++; $display("FAIL mask_regrant c5 got=%b exp=00", {mem_re, fetch_done}); end
        fetch_req = 1'b0;
        tick();
    endtask

    // Reset in the middle of a read aborts it.
    task automatic test_reset_abort();
        fetch_req = 1'b1; fetch_addr = 16'h0020; mem_rdata = 16'h9999;
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++; if ({mem_re, mem_we, fetch_done} !== 3'b000) begin failures++; $display("FAIL abort_strobes c3 got=%b exp=000", {mem_re, mem_we, fetch_done}); end
        checks++; if (fetch_rdata !== 16'h0) begin failures++; $display("FAIL abort_rdata c3 got=%h exp=0000", fetch_rdata); end
        reset = 1'b0; fetch_req = 1'b0;
        tick();
        checks++; if ({fetch_done, mem_re, fetch_rdata} !== 18'h0) begin failures++; $display("FAIL abort_idle c4 got=%b/%h exp=00/0000", {fetch_done, mem_re}, fetch_rdata); end
        tick();
        checks++; if ({fetch_done, mem_re, need_wait} !== 3'b000) begin failures++; $display("FAIL abort_idle c5 got=%b exp=000", {fetch_done, mem_re, need_wait}); end
    endtask

    // Zero-wait-state build: one access cycle, done at cycle 2.
    task automatic test_wait0();
        f0_req = 1'b1; f0_addr = 16'h0055; m0_rdata = 16'hCAFE;
        tick();
        checks++; if ({m0_re, f0_done, m0_addr} !== {2'b10, 16'h0055}) begin failures++; $display("FAIL w0_access c1 got=%b/%h exp=10/0055", {m0_re, f0_done}, m0_addr); end
        tick();
        checks++; if ({m0_re, f0_done, f0_rdata} !== {2'b01, 16'hCAFE}) begin failures++; $display("FAIL w0_done c2 got=%b/%h exp=01/cafe", {m0_re, f0_done}, f0_rdata); end
        f0_req = 1'b0;
        tick();
        checks++; if ({m0_re, f0_done} !== 2'b00) begin failures++; $display("FAIL w0_pulse c3 got=%b exp=00", {m0_re, f0_done}); end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_priority_back_to_back();
        test_write();
        test_mask();
        test_reset_abort();
        test_wait0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
